led_serial_ctrl: RTL and testbench



---
 rtl/led_serial_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_led_serial_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/led_serial_ctrl.sv
// Serial driver for the shift-register LED bank: shifts a WIDTH-bit pattern out on
// led_do/led_clk, then latches it and enables the outputs.
module led_serial_ctrl #(
  parameter int WIDTH     = 16,
  parameter int DIV       = 2,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit INVERT    = 1'b1,
  parameter bit AUTO_LOAD = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             busy,
  output logic             done,
  output logic             led_do,
  output logic             led_clk,
  output logic             led_pen,
  output logic             led_clr
);

  localparam int DW = $clog2(DIV + 1);
  localparam int BW = $clog2(WIDTH);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [DW-1:0]    div_r;
  logic [DW-1:0]    div_s;
  logic [BW-1:0]    bit_r;
  logic [BW-1:0]    bit_s;
  logic [WIDTH-1:0] shift_r;
  logic [WIDTH-1:0] shift_s;
  logic [WIDTH-1:0] last_r;
  logic [WIDTH-1:0] last_s;
  logic             pending_r;
  logic             pending_s;
  logic             trigger_s;
  logic             phase_end_s;
  logic             start_s;
  logic             advance_s;

  logic             busy_r;
  logic             done_r;
  logic             led_do_r;
  logic             led_clk_r;
  logic             led_pen_r;
  logic             led_clr_r;

  // Bit presented first in the given shift-register image.
  function automatic logic head_bit(input logic [WIDTH-1:0] v);
    logic b;
    if (MSB_FIRST) begin
      b = v[WIDTH-1];
    end else begin
      b = v[0];
    end
    return b;
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    if (MSB_FIRST) begin
      r = {v[WIDTH-2:0], 1'b0};
    end else begin
      r = {1'b0, v[WIDTH-1:1]};
    end
    return r;
  endfunction

  // Frame request qualification and divider phase end for this cycle.
  always_comb begin
    trigger_s   = load | (AUTO_LOAD & (data_in != last_r));
    phase_end_s = (div_r == DIV_LAST);
  end

  // Next-state logic: each bit is DIV cycles low then DIV cycles high on led_clk.
  always_comb begin
    state_s   = state_r;
    div_s     = div_r;
    bit_s     = bit_r;
    start_s   = 1'b0;
    advance_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (trigger_s) begin
          start_s = 1'b1;
          state_s = SHIFT_LO;
          div_s   = '0;
          bit_s   = '0;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT_LO: begin
        if (phase_end_s) begin
          state_s = SHIFT_HI;
          div_s   = '0;
        end else begin
          div_s = div_r + DW'(1);
        end
      end
      SHIFT_HI: begin
        if (phase_end_s) begin
          div_s = '0;
          if (bit_r == BIT_LAST) begin
            state_s = LATCH;
          end else begin
            state_s   = SHIFT_LO;
            bit_s     = bit_r + BW'(1);
            advance_s = 1'b1;
          end
        end else begin
          div_s = div_r + DW'(1);
        end
      end
      LATCH: begin
        if (phase_end_s) begin
          div_s = '0;
          bit_s = '0;
          // A request seen at any time during the frame restarts with no idle gap.
          if (pending_r | trigger_s) begin
            start_s = 1'b1;
            state_s = SHIFT_LO;
          end else begin
            state_s = IDLE;
          end
        end else begin
          div_s = div_r + DW'(1);
        end
      end
      default: begin
        state_s = IDLE;
        div_s   = '0;
        bit_s   = '0;
      end
    endcase
  end

  // Datapath next values: capture at frame start, shift at bit boundaries.
  always_comb begin
    shift_s   = start_s ? data_in : (advance_s ? advance(shift_r) : shift_r);
    last_s    = start_s ? data_in : last_r;
    pending_s = start_s ? 1'b0
              : ((state_r != IDLE) ? (pending_r | trigger_s) : pending_r);
  end

  // FSM, counters and frame datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      div_r     <= '0;
      bit_r     <= '0;
      shift_r   <= '0;
      last_r    <= '0;
      pending_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      div_r     <= div_s;
      bit_r     <= bit_s;
      shift_r   <= shift_s;
      last_r    <= last_s;
      pending_r <= pending_s;
    end
  end

  // Registered outputs, derived from the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      led_do_r  <= 1'b0;
      led_clk_r <= 1'b0;
      led_pen_r <= 1'b0;
      led_clr_r <= 1'b0;
    end else begin
      busy_r    <= (state_s != IDLE);
      done_r    <= (state_s == LATCH) && (div_s == DIV_LAST);
      led_clk_r <= (state_s == SHIFT_HI);
      led_clr_r <= 1'b1;
      // Data only moves on entry to the low half, so it is stable across the rising edge.
      if (state_s == SHIFT_LO) begin
        led_do_r <= head_bit(shift_s) ^ INVERT;
      end else begin
        led_do_r <= led_do_r;
      end
      if ((state_r == LATCH) && phase_end_s) begin
        led_pen_r <= 1'b1;
      end else begin
        led_pen_r <= led_pen_r;
      end
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign led_do  = led_do_r;
  assign led_clk = led_clk_r;
  assign led_pen = led_pen_r;
  assign led_clr = led_clr_r;

endmodule

// File: tb/tb_led_serial_ctrl.sv
// Four differently parameterised led_serial_ctrl instances under directed and random
// traffic, checked against a frame-level reference model and a data scoreboard.
module tb_led_serial_ctrl;

  localparam int W = 16;

  logic clk = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input int lane_id,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s lane%0d t=%0t: got %0h expected %0h", name, lane_id, $time, act, exp);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : lane
    localparam int D   = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 3 : 4;
    localparam bit MF  = (g == 0 || g == 2);
    localparam bit INV = (g == 0 || g == 3);
    localparam bit AL  = (g >= 2);
    localparam logic [W-1:0] FIRST = (g == 0) ? 16'hA5F0 : (g == 1) ? 16'h0001 : 16'h00FF;
    localparam int F   = (2 * W + 1) * D;

    logic         rst  = 1'b1;
    logic         load = 1'b0;
    logic [W-1:0] din  = '0;
    logic         busy, done, led_do, led_clk, led_pen, led_clr;
    bit           fin  = 1'b0;

    led_serial_ctrl #(
      .WIDTH(W), .DIV(D), .MSB_FIRST(MF), .INVERT(INV), .AUTO_LOAD(AL)
    ) dut (
      .clk(clk), .reset(rst), .data_in(din), .load(load),
      .busy(busy), .done(done), .led_do(led_do), .led_clk(led_clk),
      .led_pen(led_pen), .led_clr(led_clr)
    );

    // Reference model: a frame is F busy cycles counted down from its start edge.
    int           rem    = 0;
    bit           pend_m = 1'b0;
    bit           trig_m = 1'b0;
    logic [W-1:0] last_m = '0;
    bit           pen_m  = 1'b0;
    bit           clr_m  = 1'b0;
    logic [W-1:0] expq[$];

    initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        rem = 0; pend_m = 1'b0; last_m = '0; pen_m = 1'b0; clr_m = 1'b0;
        expq.delete();
      end else begin
        clr_m  = 1'b1;
        trig_m = load || (AL && (din != last_m));
        if (rem == 1) pen_m = 1'b1;
        if (rem <= 1) begin
          if (trig_m || pend_m) begin
            expq.push_back(din);
            last_m = din;
            rem    = F;
            pend_m = 1'b0;
          end else begin
            rem = 0;
          end
        end else begin
          pend_m = pend_m || trig_m;
          rem    = rem - 1;
        end
      end
    end

    // Monitor: per-cycle control checks plus frame reassembly against the scoreboard.
    int           nbits = 0, cyc = 0, last_chg = 0, frames_seen = 0;
    logic [W-1:0] asm_v = '0;
    logic [W-1:0] exp_v;
    logic         prev_clk = 1'b0, prev_do = 1'b0;

    initial forever begin
      @(negedge clk);
      cyc++;
      chk("busy", g, busy, rem > 0);
      chk("done", g, done, rem == 1);
      chk("led_pen", g, led_pen, pen_m);
      chk("led_clr", g, led_clr, clr_m);
      if (rem == 0) chk("led_clk_idle", g, led_clk, 0);
      if (rst) begin
        nbits = 0;
        asm_v = '0;
      end else begin
        if (led_do !== prev_do) begin
          chk("do_change_clk_low", g, led_clk, 0);
          last_chg = cyc;
        end
        if (led_clk && !prev_clk) begin
          chk("do_setup", g, (cyc - last_chg) >= D, 1);
          if (nbits < W) begin
            if (MF) asm_v[W-1-nbits] = led_do ^ INV;
            else    asm_v[nbits]     = led_do ^ INV;
          end
          nbits++;
        end
        if (done) begin
          frames_seen++;
          chk("frame_bits", g, nbits, W);
          chk("frame_queued", g, expq.size() > 0, 1);
          if (expq.size() > 0) begin
            exp_v = expq.pop_front();
            chk("frame_data", g, asm_v, exp_v);
          end
          nbits = 0;
        end
      end
      prev_clk = led_clk;
      prev_do  = led_do;
    end

    task automatic wait_idle(input string tag);
      int t = 0;
      while (rem != 0 && t < 4000) begin
        @(posedge clk);
        t++;
      end
      chk(tag, g, rem == 0, 1);
      #1;
    endtask

    int f0;

    initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      // First frame: explicit load, or a data change alone on auto-load lanes.
      #1 din = FIRST; load = !AL;
      @(posedge clk); #1 load = 1'b0;
      wait_idle("first_idle");
      chk("first_frame_count", g, frames_seen, 1);
      chk("pen_after_first", g, led_pen, 1);
      repeat (3 * F) @(posedge clk);
      #1 chk("no_spurious_frame", g, frames_seen, 1);

      // Several requests during one frame collapse into a single follow-up frame.
      f0  = frames_seen;
      din = FIRST ^ 16'h0F0F; load = 1'b1;
      @(posedge clk); #1 load = 1'b0;
      for (int k = 0; k < 3; k++) begin
        repeat (5) @(posedge clk);
        #1 load = 1'b1;
        @(posedge clk); #1 load = 1'b0;
      end
      din = 16'h1234;
      wait_idle("pending_idle");
      chk("followup_frames", g, frames_seen - f0, 2);

      // Reset around bit 7 with a request pending.
      din = 16'hC3A5; load = 1'b1;
      @(posedge clk); #1 load = 1'b0;
      for (int t = 0; t < 400 && nbits < 7; t++) @(posedge clk);
      chk("reach_bit7", g, nbits >= 7, 1);
      #1 load = 1'b1;
      @(posedge clk); #2 load = 1'b0; rst = 1'b1; din = '0;
      #1;
      chk("rst_busy", g, busy, 0);
      chk("rst_done", g, done, 0);
      chk("rst_led_do", g, led_do, 0);
      chk("rst_led_clk", g, led_clk, 0);
      chk("rst_led_pen", g, led_pen, 0);
      chk("rst_led_clr", g, led_clr, 0);
      f0 = frames_seen;
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk); #1;
      chk("clr_after_release", g, led_clr, 1);
      repeat (2 * F) @(posedge clk);
      #1 chk("pending_dropped", g, frames_seen - f0, 0);

      // Random traffic.
      for (int i = 0; i < 30; i++) begin
        repeat ($urandom_range(0, (3 * F) / 2)) @(posedge clk);
        #1;
        case ($urandom_range(0, 3))
          0: load = 1'b1;
          1: din = 16'($urandom);
          2: begin load = 1'b1; din = 16'($urandom); end
          default: din = din ^ (16'h0001 << $urandom_range(0, W - 1));
        endcase
        @(posedge clk); #1 load = 1'b0;
      end
      wait_idle("final_idle");
      repeat (2) @(posedge clk);
      #1 chk("queue_drained", g, expq.size(), 0);
      fin = 1'b1;
    end
  end

  initial begin
    for (int t = 0; t < 60000; t++) begin
      @(posedge clk);
      if (lane[0].fin && lane[1].fin && lane[2].fin && lane[3].fin) break;
    end
    chk("all_lanes_finished", -1,
        lane[0].fin && lane[1].fin && lane[2].fin && lane[3].fin, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
